// File: rtl/win_stream_buffer.sv
// win_stream_buffer: raster pixel stream -> 16x16 candidate windows for ncc.
// Ports: clk/rst (sync, active-low), region_start, pix_valid/pix_in/pix_ready,
//   done_with_window_data, window_data_ready, windowIn[row][col], win_index,
//   region_done.
module win_stream_buffer #(
  parameter int SEARCH_W = 48,
  parameter int SEARCH_H = 48,
  parameter int WIN      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              region_start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_in,
  output logic              pix_ready,
  input  logic              done_with_window_data,
  output logic              window_data_ready,
  output logic signed [8:0] windowIn [WIN-1:0][WIN-1:0],
  output logic [12:0]       win_index,
  output logic              region_done
);

  localparam int CW = $clog2(SEARCH_W);
  localparam int RW = $clog2(SEARCH_H);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_rst_held;
  logic          r_last;
  logic [7:0]    r_lb [WIN-2:0][SEARCH_W-1:0];

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_accept;
  logic          w_win;
  logic          w_lastpix;
  logic          w_col_end;
  logic          w_row_end;
  logic [12:0]   w_ridx;
  logic [12:0]   w_cidx;
  logic [12:0]   w_idx;

  // A region_start pixel is taken as row 0 col 0 of the new region,
  // so the accept path works on the already-cleared coordinates.
  assign w_col = region_start ? '0 : r_col;
  assign w_row = region_start ? '0 : r_row;

  assign pix_ready = rst & ~r_rst_held &
                     ((r_state == S_IDLE) | region_start);
  assign w_accept  = pix_valid & pix_ready;

  assign w_win = (w_row >= RW'(WIN-1)) &&
                 (w_col >= CW'(WIN-1));
  assign w_col_end = (w_col == CW'(SEARCH_W-1));
  assign w_row_end = (w_row == RW'(SEARCH_H-1));
  assign w_lastpix = w_col_end & w_row_end;

  assign w_ridx = 13'(w_row) - 13'(WIN-1);
  assign w_cidx = 13'(w_col) - 13'(WIN-1);
  assign w_idx  = 13'(w_ridx * 13'(SEARCH_W-WIN+1)) + w_cidx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_col             <= '0;
      r_row             <= '0;
      r_rst_held        <= 1'b1;
      r_last            <= 1'b0;
      window_data_ready <= 1'b0;
      win_index         <= '0;
      region_done       <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          windowIn[i][j] <= '0;
        end
      end
      for (int k = 0; k < WIN-1; k++) begin
        for (int c = 0; c < SEARCH_W; c++) begin
          r_lb[k][c] <= '0;
        end
      end
    end else begin
      r_rst_held        <= 1'b0;
      window_data_ready <= 1'b0;
      region_done       <= 1'b0;

      if (region_start) begin
        r_state <= S_IDLE;
        r_last  <= 1'b0;
        r_col   <= '0;
        r_row   <= '0;
      end else begin
        unique case (r_state)
          S_PRESENT: r_state <= S_WAIT;
          S_WAIT: begin
            if (done_with_window_data) begin
              r_state     <= S_IDLE;
              region_done <= r_last;
              r_last      <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (w_accept) begin
        for (int i = 0; i < WIN; i++) begin
          for (int j = 0; j < WIN-1; j++) begin
            windowIn[i][j] <= windowIn[i][j+1];
          end
        end
        // Column w_col of the line buffers is a vertical shift
        // register: index 0 is the oldest stored row.
        for (int i = 0; i < WIN-1; i++) begin
          windowIn[i][WIN-1] <= $signed({1'b0, r_lb[i][w_col]});
        end
        windowIn[WIN-1][WIN-1] <= $signed({1'b0, pix_in});
        for (int k = 0; k < WIN-2; k++) begin
          r_lb[k][w_col] <= r_lb[k+1][w_col];
        end
        r_lb[WIN-2][w_col] <= pix_in;

        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end

        if (w_win) begin
          r_state           <= S_PRESENT;
          window_data_ready <= 1'b1;
          win_index         <= w_idx;
          r_last            <= w_lastpix;
        end
      end
    end
  end

endmodule

// File: tb/tb_win_stream_buffer.sv
// tb_win_stream_buffer: directed bench for win_stream_buffer.
// Ramp/pattern regions, backpressure, full region and reset/restart.
module tb_win_stream_buffer;

  logic              clk = 1'b0;
  logic              rst;
  logic              region_start;
  logic              pix_valid;
  logic [7:0]        pix_in;
  logic              pix_ready;
  logic              done_with_window_data;
  logic              window_data_ready;
  logic signed [8:0] windowIn [15:0][15:0];
  logic [12:0]       win_index;
  logic              region_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_ready = 0;
  int   n_done = 0;
  int   last_idx = -1;
  int   pend_idx = 0;
  int   mode = 0;
  logic pend = 1'b0;

  always #5 clk = ~clk;

  win_stream_buffer #(
    .SEARCH_W(48),
    .SEARCH_H(48),
    .WIN(16)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .region_start         (region_start),
    .pix_valid            (pix_valid),
    .pix_in               (pix_in),
    .pix_ready            (pix_ready),
    .done_with_window_data(done_with_window_data),
    .window_data_ready    (window_data_ready),
    .windowIn             (windowIn),
    .win_index            (win_index),
    .region_done          (region_done)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_f(input int n);
    int c;
    c = n % 48;
    if (mode == 1) return (c % 2 == 1) ? 8'd2 : 8'd0;
    return 8'(n);
  endfunction

  // Called at a negedge with inputs already driven; returns at the
  // next negedge after checking the ready pulse that should follow.
  task automatic step();
    logic acc;
    int   r;
    int   c;
    acc = pix_valid & pix_ready;
    @(posedge clk);
    pend = 1'b0;
    if (acc === 1'b1) begin
      r = n_acc / 48;
      c = n_acc % 48;
      if (r >= 15 && c >= 15) begin
        pend     = 1'b1;
        pend_idx = (r - 15) * 33 + (c - 15);
      end
      n_acc++;
    end
    @(negedge clk);
    if (pend || window_data_ready === 1'b1) begin
      chk("ready_pulse", window_data_ready, pend);
      if (pend && window_data_ready === 1'b1)
        chk("win_index", win_index, pend_idx);
    end
    if (window_data_ready === 1'b1) begin
      n_ready++;
      last_idx = win_index;
    end
    if (region_done === 1'b1) n_done++;
  endtask

  task automatic run_to(input int target);
    int cyc;
    cyc = 0;
    while (n_acc < target && cyc < 6000) begin
      pix_in    = pix_f(n_acc);
      pix_valid = 1'b1;
      step();
      cyc++;
    end
    pix_valid = 1'b0;
    if (n_acc < target) chk("timeout", n_acc, target);
  endtask

  task automatic chk_first(input string tag);
    chk({tag, "_w00"}, windowIn[0][0], 0);
    chk({tag, "_w0_15"}, windowIn[0][15], 15);
    chk({tag, "_w15_15"}, windowIn[15][15], 223);
    chk({tag, "_w15_0"}, windowIn[15][0], 208);
    chk({tag, "_idx"}, last_idx, 0);
  endtask

  initial begin
    int errs;
    rst = 1'b0;
    region_start = 1'b0;
    pix_valid = 1'b0;
    pix_in = 8'd0;
    done_with_window_data = 1'b1;
    @(negedge clk);
    repeat (3) step();
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_wdr", window_data_ready, 0);
    chk("rst_idx", win_index, 0);
    chk("rst_rdone", region_done, 0);
    chk("rst_win", windowIn[15][15], 0);
    rst = 1'b1;
    chk("rst_rel_pre", pix_ready, 0);
    step();
    chk("rst_rel_post", pix_ready, 1);
    n_acc = 0;

    // first window of a ramp region
    run_to(736);
    chk("first_cnt", n_ready, 1);
    chk_first("t1");

    // backpressure from the PRESENT cycle on
    done_with_window_data = 1'b0;
    pix_valid = 1'b1;
    pix_in = pix_f(n_acc);
    repeat (10) step();
    chk("bp_acc", n_acc, 736);
    chk("bp_ready", pix_ready, 0);
    chk("bp_hold", windowIn[15][15], 223);
    chk("bp_hold_idx", win_index, 0);
    done_with_window_data = 1'b1;
    step();
    chk("bp_release", pix_ready, 1);

    // row 15 tail and row 16 head
    run_to(768);
    chk("idx_r15c47", last_idx, 32);
    run_to(784);
    chk("idx_r16c15", last_idx, 33);
    chk("cnt_r16c15", n_ready, 34);

    // rest of the region
    run_to(2304);
    repeat (4) step();
    chk("full_cnt", n_ready, 1089);
    chk("full_last", last_idx, 1088);
    chk("full_rdone", n_done, 1);
    chk("full_ready", pix_ready, 1);
    n_acc = 0;

    // alternating 0/2 column pattern in the next region
    mode = 1;
    run_to(736);
    chk("pat_cnt", n_ready, 1090);
    chk("pat_idx", last_idx, 0);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (windowIn[i][j] !== ((j % 2 == 1) ? 9'sd2 : 9'sd0))
          errs++;
      end
    end
    chk("pat_win", errs, 0);

    // reset during WAIT, then a restart mid-row
    done_with_window_data = 1'b0;
    repeat (2) step();
    chk("wait_stall", pix_ready, 0);
    rst = 1'b0;
    repeat (2) step();
    n_acc = 0;
    chk("mid_rst_ready", pix_ready, 0);
    chk("mid_rst_wdr", window_data_ready, 0);
    chk("mid_rst_idx", win_index, 0);
    chk("mid_rst_win", windowIn[15][15], 0);
    rst = 1'b1;
    done_with_window_data = 1'b1;
    mode = 0;
    step();
    run_to(20);
    n_acc = 0;
    pix_in = pix_f(0);
    pix_valid = 1'b1;
    region_start = 1'b1;
    step();
    region_start = 1'b0;
    chk("rs_acc", n_acc, 1);
    run_to(736);
    chk("rs_cnt", n_ready, 1091);
    chk_first("t6");
    chk("rs_rdone", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
